// File: rtl/output_pkg.sv
// Shared definitions for the output matrix register and the output serializer.
package output_pkg;

    localparam int unsigned ELEM_W = 16;
    localparam int unsigned DIM    = 4;
    localparam int unsigned MAT_W  = ELEM_W * DIM * DIM;
    localparam int unsigned IDX_W  = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM * DIM - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/output_serializer.sv
// Streams a captured 4x4 matrix out row-major over a valid/ready port.
// Optional one-deep pending matrix buffer: define OUTPUT_SERIALIZER_PENDING_EN.
module output_serializer
    import output_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [MAT_W-1:0]     matrix_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ELEM_W-1:0]    out_data,
    output logic [1:0]           out_row,
    output logic [1:0]           out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [MAT_W-1:0]   shadow_q, shadow_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               xfer, last_xfer;
`ifdef OUTPUT_SERIALIZER_PENDING_EN
    logic [MAT_W-1:0]   pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
`endif

    assign xfer      = (state_q == STREAM) && out_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q;
        done_d    = last_xfer;
`ifdef OUTPUT_SERIALIZER_PENDING_EN
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shadow_d = matrix_in;
                    idx_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer) begin
                    idx_d = '0;
`ifdef OUTPUT_SERIALIZER_PENDING_EN
                    // Older pending matrix goes first; a coincident load refills pending.
                    if (pend_vld_q) begin
                        shadow_d = pend_q;
                        if (load) pend_d = matrix_in;
                        else      pend_vld_d = 1'b0;
                    end else if (load) begin
                        shadow_d = matrix_in;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    if (load) shadow_d = matrix_in;
                    else      state_d  = IDLE;
`endif
                end else begin
                    if (xfer) idx_d = idx_q + 1'b1;
                    if (load) begin
`ifdef OUTPUT_SERIALIZER_PENDING_EN
                        if (!pend_vld_q) begin
                            pend_d     = matrix_in;
                            pend_vld_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
`else
                        overrun_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef OUTPUT_SERIALIZER_PENDING_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end
`endif

    assign busy      = (state_q == STREAM);
    assign out_valid = busy;
    assign out_data  = busy ? shadow_q[idx_q*ELEM_W +: ELEM_W] : '0;
    assign out_row   = busy ? idx_q[3:2] : '0;
    assign out_col   = busy ? idx_q[1:0] : '0;
    assign out_last  = busy && (idx_q == LAST_IDX);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_output_serializer.sv
// Directed self-checking bench for output_serializer; covers OUTPUT_SERIALIZER_PENDING_EN when defined.
module tb_output_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [255:0] matrix_in;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         busy;
    logic         done;
    logic         overrun;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    output_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .matrix_in (matrix_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [15:0] base);
        logic [255:0] m;
        for (int k = 0; k < 16; k++) m[k*16 +: 16] = base + 16'(k);
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_elem(input string tag, input logic [15:0] base, input int k);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(base + 16'(k)));
        check({tag, "_row"},   32'(out_row),   32'(k / 4));
        check({tag, "_col"},   32'(out_col),   32'(k % 4));
        check({tag, "_last"},  32'(out_last),  32'(k == 15));
    endtask

    task automatic start(input logic [15:0] base);
        matrix_in = mk(base);
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; load = 1'b0; out_ready = 1'b0; matrix_in = '0;
        #12;
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_data",    32'(out_data),  32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_done",    32'(done),      32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        check("rst_rowcol",  32'({out_row, out_col}), 32'd0);
        step();
        rst = 1'b0;
        step();

        // T1: full-speed stream
        out_ready = 1'b1;
        matrix_in = mk(16'h0100);
        load = 1'b1;
        check("t1_prevalid", 32'(out_valid), 32'd0);
        step();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_elem("t1", 16'h0100, i);
            step();
        end
        check("t1_done",  32'(done),      32'd1);
        check("t1_busy",  32'(busy),      32'd0);
        check("t1_valid", 32'(out_valid), 32'd0);
        step();
        check("t1_done_clr", 32'(done), 32'd0);

        // T2: ready pattern 1,0,0,1
        start(16'h0100);
        k = 0; cyc = 0;
        while (k < 16 && cyc < 200) begin
            out_ready = pat[cyc % 4];
            check("t2_data", 32'(out_data), 32'(16'h0100 + 16'(k)));
            check("t2_last", 32'(out_last), 32'(k == 15));
            step();
            if (out_ready) k++;
            cyc++;
        end
        check("t2_xfers", 32'(k), 32'd16);
        check("t2_done",  32'(done), 32'd1);
        check("t2_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();

        // T3: load coincident with the last transfer
        start(16'h0100);
        for (int i = 0; i < 15; i++) begin
            check_elem("t3a", 16'h0100, i);
            step();
        end
        check_elem("t3a", 16'h0100, 15);
        matrix_in = mk(16'hA000);
        load = 1'b1;
        step();
        load = 1'b0;
        check("t3_done",    32'(done),    32'd1);
        check("t3_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check_elem("t3b", 16'hA000, i);
            step();
        end
        check("t3_done2", 32'(done), 32'd1);
        check("t3_busy",  32'(busy), 32'd0);
        step();

        // T4: load at index 5 (and at index 8 while pending is full, if present)
        start(16'h0100);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin matrix_in = mk(16'h5500); load = 1'b1; end
`ifdef OUTPUT_SERIALIZER_PENDING_EN
            if (i == 7) check("t4_ovr_mid", 32'(overrun), 32'd0);
            if (i == 8) begin matrix_in = mk(16'h7700); load = 1'b1; end
`else
            if (i == 7) check("t4_ovr_mid", 32'(overrun), 32'd1);
`endif
            check_elem("t4a", 16'h0100, i);
            step();
            load = 1'b0;
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_overrun", 32'(overrun), 32'd1);
`ifdef OUTPUT_SERIALIZER_PENDING_EN
        for (int i = 0; i < 16; i++) begin
            check_elem("t4b", 16'h5500, i);
            step();
        end
        check("t4_done2", 32'(done), 32'd1);
`endif
        check("t4_busy", 32'(busy), 32'd0);
        step();

        // T5: async reset at index 9
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("t5_ovr_clr", 32'(overrun), 32'd0);
        step();
        start(16'h0100);
        for (int i = 0; i < 9; i++) step();
        check_elem("t5", 16'h0100, 9);
        #2;
        rst = 1'b1;
        #1;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_data",  32'(out_data),  32'd0);
        check("t5_busy",  32'(busy),      32'd0);
        check("t5_rowcol", 32'({out_row, out_col}), 32'd0);
        check("t5_last",  32'(out_last),  32'd0);
        step();
        rst = 1'b0;
        check("t5_done", 32'(done), 32'd0);
        step();
        check("t5_done2", 32'(done), 32'd0);

        // T6: matrix_in changes after the load do not leak into the stream
        start(16'hA000);
        matrix_in = mk(16'hEE00);
        for (int i = 0; i < 16; i++) begin
            check_elem("t6", 16'hA000, i);
            if (i == 7) matrix_in = mk(16'h3300);
            step();
        end
        check("t6_done", 32'(done), 32'd1);
        check("t6_overrun", 32'(overrun), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Downstream consumer of the 256-bit output matrix register.
- Captures one 4x4 matrix of 16-bit elements and streams it out one element per handshake over a 16-bit valid/ready port.
- Elements go out in row-major order, from row0 col0 to row3 col3.
- Provides the system-level result readout path, for example to a host interface or a test monitor.

Parameters:
- ELEM_W, 16: element width in bits.
- DIM, 4: matrix rows and columns. The matrix is square.
- MAT_W, ELEM_W*DIM*DIM = 256: width of the matrix bus.
- IDX_W, 4: element index width, log2(DIM*DIM).

Ports:
- clk, in, 1: system clock. All state is updated on the rising edge.
- rst, in, 1: asynchronous reset, active-high.
- load, in, 1: one-cycle strobe. Asserted when the output register holds a new matrix.
- matrix_in, in, MAT_W: matrix from the output register. Element k is in bits [16k+15:16k].
- out_valid, out, 1: out_data holds a valid element.
- out_ready, in, 1: the consumer accepts the element this cycle.
- out_data, out, ELEM_W: current element.
- out_row, out, 2: row of the current element (k/4).
- out_col, out, 2: column of the current element (k%4).
- out_last, out, 1: high with element 15.
- busy, out, 1: a stream is in progress (state STREAM).
- done, out, 1: one-cycle pulse in the cycle after the element-15 transfer.
- overrun, out, 1: sticky flag. Set when a load is dropped. Cleared only by rst.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the index goes to 0.
  - The shadow matrix is cleared to 0.
  - out_valid, out_last, busy, done and overrun are 0. out_data, out_row and out_col are 0.
  - Reset mid-stream aborts the stream immediately. There is no partial completion and no done pulse.
- FSM has two states:
  - IDLE: load=1 latches matrix_in into the shadow register, sets index=0 and moves to STREAM.
  - STREAM: out_valid=1. out_data, out_row and out_col reflect the shadow element at the current index.
- Latency: load at edge N gives out_valid=1 with element 0 from edge N+1 onward.
- A transfer happens when out_valid and out_ready are both 1 at a clock edge. The index then increments.
- While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold steady.
- out_last is 1 iff index == 15 in STREAM.
- A transfer at index 15 does two things:
  - done pulses the next cycle.
  - The FSM returns to IDLE, unless a load is taken the same cycle (see below).
- Simultaneous load and last transfer: the load is accepted. The shadow is reloaded, the index goes to 0 and the FSM stays in STREAM. Streaming continues back-to-back with no bubble, and done still pulses.
- A load in STREAM when the last transfer is not happening is dropped, and overrun is set to 1. The exception is the pending buffer under the optional feature.
- Index wrap from 15 happens only through a reload or a return to IDLE. The index never free-runs.
- matrix_in is sampled only on an accepted load. Later changes to matrix_in do not affect the stream.

Optional Feature:
- Macro OUTPUT_SERIALIZER_PENDING_EN.
- Defined: adds a one-deep pending matrix buffer and a pending_valid bit.
  - A load in STREAM without a same-cycle last transfer fills the pending buffer.
  - When the last transfer happens with pending_valid=1, the pending buffer moves to the shadow, the index goes to 0, the FSM stays in STREAM and pending_valid is cleared. done still pulses.
  - A load while pending_valid=1 is dropped, overrun is set, and the pending buffer keeps its first contents.
  - rst clears pending_valid.
- Not defined: no pending storage. Loads during an active stream are dropped and set overrun, as described in Behaviour.

Decomposition:
- Shared package output_pkg holds ELEM_W, DIM, MAT_W, IDX_W and the state encoding (IDLE=0, STREAM=1).
- The same package is used by the output register and this block.
- No sub-module is needed. Element selection is an indexed part-select on the shadow register.

Test Plan:
- Reset, then load with element k = 16'h0100+k, out_ready held at 1:
  - out_valid rises one cycle after load.
  - out_data runs 0x0100 to 0x010F on consecutive cycles, row/col run (0,0) to (3,3), and out_last=1 only on 0x010F.
  - done pulses once, then busy=0.
- Same matrix with out_ready toggled 1,0,0,1,...: each element holds while ready=0. No element is skipped or repeated, and there are exactly 16 transfers.
- Second load (element k = 0xA000+k) in the same cycle as element-15 transfer: 0xA000 follows 0x010F with no gap, done pulses, overrun=0.
- Load at index 5 of a stream:
  - Without the macro: the stream completes unchanged and overrun=1.
  - With the macro: the second matrix streams after element 15, and overrun stays 0. A third load during that window sets overrun=1.
- rst asserted at index 9 mid-stream: outputs go to 0 asynchronously with no done pulse. A fresh load afterwards streams from element 0.
- Change matrix_in during a stream after the load: out_data still reflects the latched values.
